// File: rtl/dino_motion_engine_pkg.sv
// Shared types and default tuning constants for the dino motion engine and the
// display stage that consumes its outputs.
package dino_pkg;

    // The encoding doubles as the sprite-ROM select driven to the display.
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        JUMP = 2'b01,
        DUCK = 2'b10,
        DEAD = 2'b11
    } dino_state_t;

    localparam int unsigned Y_W_D      = 8;
    localparam int unsigned GROUND_Y_D = 100;
    localparam int unsigned JUMP_V0_D  = 10;
    localparam int unsigned GRAVITY_D  = 1;
    localparam int unsigned ANIM_DIV_D = 6;

endpackage

// File: rtl/dino_motion_engine_if.sv
// Player/collision inputs and registered pose outputs between the game control
// logic (master) and the dino motion engine (slave).
interface dino_motion_engine_if #(
    parameter int unsigned Y_W = 8
);
    logic           frame_tick;
    logic           jump_req;
    logic           duck_req;
    logic           collide;
    logic           restart;
    logic [Y_W-1:0] dino_y;
    logic [1:0]     sprite_sel;
    logic           anim_phase;
    logic           airborne;

    modport master (
        output frame_tick, jump_req, duck_req, collide, restart,
        input  dino_y, sprite_sel, anim_phase, airborne
    );

    modport slave (
        input  frame_tick, jump_req, duck_req, collide, restart,
        output dino_y, sprite_sel, anim_phase, airborne
    );
endinterface

// File: rtl/dino_motion_engine.sv
// Per-frame dino movement: jump ballistics, duck/run pose, death and restart,
// producing registered y-position and sprite selection for the display.
module dino_motion_engine
    import dino_pkg::*;
#(
    parameter int unsigned Y_W      = Y_W_D,
    parameter int unsigned GROUND_Y = GROUND_Y_D,
    parameter int unsigned JUMP_V0  = JUMP_V0_D,
    parameter int unsigned GRAVITY  = GRAVITY_D,
    parameter int unsigned ANIM_DIV = ANIM_DIV_D
) (
    input  logic                 clk,
    input  logic                 reset,
    dino_motion_engine_if.slave  bus
);

    localparam int unsigned VW = Y_W + 1;
    localparam int unsigned PW = Y_W + 2;
    localparam int unsigned CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic signed [VW-1:0] V0       = VW'(JUMP_V0);
    localparam logic signed [VW-1:0] G1       = VW'(GRAVITY);
    localparam logic signed [VW-1:0] G2       = VW'(2 * GRAVITY);
    localparam logic signed [PW-1:0] GROUND_P = PW'(GROUND_Y);
    localparam logic [Y_W-1:0]       GROUND   = Y_W'(GROUND_Y);
    localparam logic [CW-1:0]        CNT_WRAP = CW'(ANIM_DIV - 1);

    dino_state_t           state, state_nxt;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [VW-1:0]  vel_q, vel_d;
    logic                  pend_q, pend_d;
    logic                  air_q;
    logic [CW-1:0]         anim_cnt;
    logic                  anim_q;

    logic                  jump_eff;
    logic                  launch;
    logic signed [VW-1:0]  vel_src;
    logic signed [VW-1:0]  fall_step;
    logic signed [PW-1:0]  y_move;
    logic                  vel_le0;

    // A request arriving in the same cycle as the tick is honoured immediately.
    assign jump_eff  = pend_q | bus.jump_req;
    assign launch    = bus.frame_tick && jump_eff && (state == RUN || state == DUCK);
    assign vel_src   = launch ? V0 : vel_q;
    assign y_move    = $signed({2'b00, y_q}) - $signed({vel_src[VW-1], vel_src});
    assign fall_step = bus.duck_req ? G2 : G1;
    assign vel_le0   = vel_q[VW-1] || (vel_q == '0);

    always_comb begin
        state_nxt = state;
        y_d       = y_q;
        vel_d     = vel_q;
        pend_d    = jump_eff;

        if (state == DEAD) begin
            pend_d = 1'b0;
            if (bus.restart) begin
                state_nxt = RUN;
                y_d       = GROUND;
                vel_d     = '0;
            end
        end else if (bus.collide) begin
            state_nxt = DEAD;
            pend_d    = 1'b0;
        end else if (bus.frame_tick) begin
            unique case (state)
                RUN, DUCK: begin
                    if (launch) begin
                        state_nxt = JUMP;
                        pend_d    = 1'b0;
                        y_d       = y_move[PW-1] ? '0 : y_move[Y_W-1:0];
                        vel_d     = V0 - G1;
                    end else if (state == RUN && bus.duck_req) begin
                        state_nxt = DUCK;
                    end else if (state == DUCK && !bus.duck_req) begin
                        state_nxt = RUN;
                    end
                end
                JUMP: begin
                    // Pending jumps survive landing and relaunch on the following tick.
                    if (y_move >= GROUND_P && vel_le0) begin
                        state_nxt = bus.duck_req ? DUCK : RUN;
                        y_d       = GROUND;
                        vel_d     = '0;
                    end else if (y_move[PW-1]) begin
                        y_d   = '0;
                        vel_d = '0;
                    end else begin
                        y_d   = y_move[Y_W-1:0];
                        vel_d = vel_q - fall_step;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            y_q    <= GROUND;
            vel_q  <= '0;
            pend_q <= 1'b0;
            air_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            y_q    <= y_d;
            vel_q  <= vel_d;
            pend_q <= pend_d;
            air_q  <= (state_nxt == JUMP);
        end
    end

    // Leg animation advances only on ticks that keep the dino running.
    always_ff @(posedge clk) begin
        if (reset) begin
            anim_cnt <= '0;
            anim_q   <= 1'b0;
        end else if (state == DEAD) begin
            if (bus.restart) begin
                anim_cnt <= '0;
                anim_q   <= 1'b0;
            end
        end else if (state_nxt != RUN) begin
            anim_cnt <= '0;
        end else if (state == RUN && bus.frame_tick) begin
            if (anim_cnt == CNT_WRAP) begin
                anim_cnt <= '0;
                anim_q   <= ~anim_q;
            end else begin
                anim_cnt <= anim_cnt + CW'(1);
            end
        end
    end

    assign bus.dino_y     = y_q;
    assign bus.sprite_sel = state;
    assign bus.anim_phase = anim_q;
    assign bus.airborne   = air_q;

endmodule

// File: tb/tb_dino_motion_engine.sv
// Directed and randomized checks of dino_motion_engine against an integer
// behavioural model of the movement rules.
module tb_dino_motion_engine;
    import dino_pkg::*;

    localparam int Y_W    = 8;
    localparam int GROUND = 100;
    localparam int V0     = 10;
    localparam int G      = 1;
    localparam int ADIV   = 6;

    localparam int MD_RUN  = 0;
    localparam int MD_JUMP = 1;
    localparam int MD_DUCK = 2;
    localparam int MD_DEAD = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dino_motion_engine_if #(.Y_W(Y_W)) bus ();

    dino_motion_engine #(
        .Y_W      (Y_W),
        .GROUND_Y (GROUND),
        .JUMP_V0  (V0),
        .GRAVITY  (G),
        .ANIM_DIV (ADIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int m_mode, m_y, m_v, m_pend, m_ticks, m_phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = MD_RUN;
        m_y     = GROUND;
        m_v     = 0;
        m_pend  = 0;
        m_ticks = 0;
        m_phase = 0;
    endtask

    task automatic model_step(input bit ft, jr, dr, co, rs, rst);
        int ny;
        bit want;
        if (rst) begin
            model_reset();
        end else if (m_mode == MD_DEAD) begin
            m_pend = 0;
            if (rs) model_reset();
        end else if (co) begin
            m_mode  = MD_DEAD;
            m_pend  = 0;
            m_ticks = 0;
        end else begin
            want   = (m_pend != 0) || jr;
            m_pend = want;
            if (ft) begin
                if ((m_mode == MD_RUN || m_mode == MD_DUCK) && want) begin
                    ny      = m_y - V0;
                    m_y     = (ny < 0) ? 0 : ny;
                    m_v     = V0 - G;
                    m_mode  = MD_JUMP;
                    m_pend  = 0;
                    m_ticks = 0;
                end else if (m_mode == MD_RUN) begin
                    if (dr) begin
                        m_mode  = MD_DUCK;
                        m_ticks = 0;
                    end else begin
                        m_ticks++;
                        if (m_ticks == ADIV) begin
                            m_ticks = 0;
                            m_phase = 1 - m_phase;
                        end
                    end
                end else if (m_mode == MD_DUCK) begin
                    if (!dr) m_mode = MD_RUN;
                end else begin
                    ny = m_y - m_v;
                    if (ny >= GROUND && m_v <= 0) begin
                        m_y    = GROUND;
                        m_v    = 0;
                        m_mode = dr ? MD_DUCK : MD_RUN;
                    end else if (ny < 0) begin
                        m_y = 0;
                        m_v = 0;
                    end else begin
                        m_y = ny;
                        m_v = m_v - (dr ? 2 * G : G);
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        check("model_y",        32'(bus.dino_y),     m_y);
        check("model_sprite",   32'(bus.sprite_sel), m_mode);
        check("model_phase",    32'(bus.anim_phase), m_phase);
        check("model_airborne", 32'(bus.airborne),   (m_mode == MD_JUMP) ? 1 : 0);
    endtask

    task automatic step(input bit ft, jr, dr, co, rs, rst);
        bus.frame_tick = ft;
        bus.jump_req   = jr;
        bus.duck_req   = dr;
        bus.collide    = co;
        bus.restart    = rs;
        reset          = rst;
        model_step(ft, jr, dr, co, rs, rst);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic frame(input bit jr, dr);
        step(1'b1, jr, dr, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, dr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int land_tick;
        bit dr_lvl;

        bus.frame_tick = 1'b0;
        bus.jump_req   = 1'b0;
        bus.duck_req   = 1'b0;
        bus.collide    = 1'b0;
        bus.restart    = 1'b0;
        reset          = 1'b1;
        model_reset();

        // Reset state and idle running animation
        do_reset();
        check("rst_y", 32'(bus.dino_y), GROUND);
        check("rst_sprite", 32'(bus.sprite_sel), 0);
        check("rst_phase", 32'(bus.anim_phase), 0);
        check("rst_air", 32'(bus.airborne), 0);
        for (int t = 1; t <= 5; t++) frame(1'b0, 1'b0);
        check("idle5_y", 32'(bus.dino_y), GROUND);
        check("idle5_phase", 32'(bus.anim_phase), 0);
        frame(1'b0, 1'b0);
        check("idle6_phase", 32'(bus.anim_phase), 1);

        // Full jump arc from a mid-frame pulse
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 21; t++) begin
            frame(1'b0, 1'b0);
            if (t == 1) begin
                check("jump_t1_y", 32'(bus.dino_y), 90);
                check("jump_t1_sprite", 32'(bus.sprite_sel), 1);
            end
            if (t == 10) check("jump_t10_y", 32'(bus.dino_y), 45);
            if (t == 11) check("jump_t11_y", 32'(bus.dino_y), 45);
        end
        check("jump_t21_y", 32'(bus.dino_y), GROUND);
        check("jump_t21_sprite", 32'(bus.sprite_sel), 0);
        check("jump_t21_air", 32'(bus.airborne), 0);

        // Fast fall with duck held from tick 3
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        land_tick = 99;
        for (int t = 3; t <= 25; t++) begin
            if (land_tick == 99) begin
                frame(1'b0, 1'b1);
                if (bus.sprite_sel != 2'b01) land_tick = t;
            end
        end
        check("duck_land_tick", land_tick, 13);
        check("duck_land_y", 32'(bus.dino_y), GROUND);
        check("duck_land_sprite", 32'(bus.sprite_sel), 2);
        frame(1'b0, 1'b0);
        check("duck_release_sprite", 32'(bus.sprite_sel), 0);

        // Collision freezes mid-jump, restart recovers
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check("pre_collide_y", 32'(bus.dino_y), 81);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dead_sprite", 32'(bus.sprite_sel), 3);
        check("dead_air", 32'(bus.airborne), 0);
        for (int t = 0; t < 3; t++) frame(1'b1, 1'b0);
        check("dead_frozen_y", 32'(bus.dino_y), 81);
        check("dead_frozen_sprite", 32'(bus.sprite_sel), 3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("restart_y", 32'(bus.dino_y), GROUND);
        check("restart_sprite", 32'(bus.sprite_sel), 0);

        // Simultaneous collide and restart
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pair_dead_sprite", 32'(bus.sprite_sel), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pair_run_sprite", 32'(bus.sprite_sel), 3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Jump beats duck on the same tick
        frame(1'b1, 1'b1);
        check("jd_sprite", 32'(bus.sprite_sel), 1);
        check("jd_y", 32'(bus.dino_y), 90);

        // Reset in the middle of a jump
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) frame(1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("midjump_rst_y", 32'(bus.dino_y), GROUND);
        check("midjump_rst_sprite", 32'(bus.sprite_sel), 0);
        check("midjump_rst_air", 32'(bus.airborne), 0);

        // Randomized traffic against the model
        dr_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) dr_lvl = ~dr_lvl;
            step($urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0,
                 dr_lvl,
                 $urandom_range(0, 127) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 499) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
